npu_ctrl_seq: RTL and testbench

//   Control sequencer directly upstream of npu_core. On START it generates the
//   CON_SIG/SSFR control words for one inference step: buffer load, MAC

---
 rtl/npu_ctrl_seq_if.sv | 33 +++
 rtl/npu_ctrl_seq.sv | 160 ++++++++++++++++
 tb/tb_npu_ctrl_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_ctrl_seq_if.sv
// Handshake and control-word bundle between the pixel feeder / host side
// and the npu_ctrl_seq sequencer.
interface npu_ctrl_seq_if #(
    parameter int CNT_W = 8
);
    logic             START;
    logic             ABORT;
    logic [CNT_W-1:0] N_MAC;
    logic [CNT_W-1:0] N_GROUPS;
    logic [1:0]       BYPASS_RELU;
    logic [2:0]       SEL_OUT_CFG;
    logic             IN_VALID;
    logic             IN_READY;
    logic             FULL;
    logic [15:0]      CON_SIG;
    logic [15:0]      SSFR;
    logic             BUSY;
    logic             DONE;

    // Host / feeder side: issues commands and group data, observes control words
    modport master (
        output START, ABORT, N_MAC, N_GROUPS, BYPASS_RELU, SEL_OUT_CFG,
        output IN_VALID, FULL,
        input  IN_READY, CON_SIG, SSFR, BUSY, DONE
    );

    // Sequencer side
    modport slave (
        input  START, ABORT, N_MAC, N_GROUPS, BYPASS_RELU, SEL_OUT_CFG,
        input  IN_VALID, FULL,
        output IN_READY, CON_SIG, SSFR, BUSY, DONE
    );
endinterface

// File: rtl/npu_ctrl_seq.sv
// Control sequencer in front of npu_core: one START produces one inference
// step (load, MAC over groups, ReLU, compare, select, FIFO write).
// All outputs come straight from flops decoded from the next state, so they
// track the state register exactly and have no input-to-output path.
module npu_ctrl_seq #(
    parameter int CNT_W       = 8,
    parameter int RELU_CYCLES = 2
) (
    input  logic           CLKEXT,
    input  logic           RST,
    npu_ctrl_seq_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_BUF, S_MAC, S_RELU,
        S_COMP, S_SEL, S_WAITF, S_WR, S_DONE
    } state_e;

    localparam logic [3:0] RELU_LAST = 4'(RELU_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] nMac_q, nMac_d;
    logic [CNT_W-1:0] nGroups_q, nGroups_d;
    logic [CNT_W-1:0] macCnt_q, macCnt_d;
    logic [CNT_W-1:0] grpCnt_q, grpCnt_d;
    logic [3:0]       reluCnt_q, reluCnt_d;
    logic [1:0]       bypass_q, bypass_d;
    logic [2:0]       selOut_q, selOut_d;
    logic [15:0]      conSig_q, conSig_d;
    logic [15:0]      ssfr_q, ssfr_d;
    logic             inReady_q, inReady_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic startAccept;
    logic macLast;
    logic groupsLeft;
    logic reluLast;

    assign startAccept = (state_q == S_IDLE) && bus.START && !bus.ABORT;
    assign macLast     = (macCnt_q == nMac_q - CNT_W'(1));
    assign groupsLeft  = (grpCnt_q < nGroups_q - CNT_W'(1));
    assign reluLast    = (reluCnt_q == RELU_LAST);

    // State, counter, latched-config and output registers
    always_ff @(posedge CLKEXT or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            nMac_q    <= '0;
            nGroups_q <= '0;
            macCnt_q  <= '0;
            grpCnt_q  <= '0;
            reluCnt_q <= '0;
            bypass_q  <= '0;
            selOut_q  <= '0;
            conSig_q  <= '0;
            ssfr_q    <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nMac_q    <= nMac_d;
            nGroups_q <= nGroups_d;
            macCnt_q  <= macCnt_d;
            grpCnt_q  <= grpCnt_d;
            reluCnt_q <= reluCnt_d;
            bypass_q  <= bypass_d;
            selOut_q  <= selOut_d;
            conSig_q  <= conSig_d;
            ssfr_q    <= ssfr_d;
            inReady_q <= inReady_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state, counters and config latch; ABORT overrides everything last
    always_comb begin
        state_d   = state_q;
        nMac_d    = nMac_q;
        nGroups_d = nGroups_q;
        bypass_d  = bypass_q;
        selOut_d  = selOut_q;
        macCnt_d  = '0;
        reluCnt_d = '0;
        grpCnt_d  = grpCnt_q;

        if (startAccept) begin
            nMac_d    = (bus.N_MAC == '0) ? CNT_W'(1) : bus.N_MAC;
            nGroups_d = (bus.N_GROUPS == '0) ? CNT_W'(1) : bus.N_GROUPS;
            bypass_d  = bus.BYPASS_RELU;
            selOut_d  = bus.SEL_OUT_CFG;
            grpCnt_d  = '0;
        end

        case (state_q)
            S_IDLE:  if (startAccept) state_d = S_LOAD;
            S_LOAD:  if (bus.IN_VALID) state_d = S_BUF;
            S_BUF:   state_d = S_MAC;
            S_MAC: begin
                if (macLast) begin
                    if (grpCnt_q != nGroups_q) grpCnt_d = grpCnt_q + CNT_W'(1);
                    state_d = groupsLeft ? S_LOAD : S_RELU;
                end else begin
                    macCnt_d = macCnt_q + CNT_W'(1);
                end
            end
            S_RELU: begin
                if (reluLast) state_d = S_COMP;
                else          reluCnt_d = reluCnt_q + 4'd1;
            end
            S_COMP:  state_d = S_SEL;
            S_SEL:   state_d = bus.FULL ? S_WAITF : S_WR;
            S_WAITF: if (!bus.FULL) state_d = S_WR;
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (bus.ABORT && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            macCnt_d  = '0;
            reluCnt_d = '0;
            grpCnt_d  = '0;
        end
    end

    // Decode the upcoming state into the control words registered next edge
    always_comb begin
        conSig_d  = 16'h0000;
        ssfr_d    = 16'h0000;
        inReady_d = (state_d == S_LOAD);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);

        if (state_d != S_IDLE) ssfr_d[12:11] = bypass_d;

        case (state_d)
            S_BUF:   conSig_d[15] = 1'b1;
            S_MAC:   conSig_d[13] = 1'b1;
            S_RELU:  conSig_d[11] = 1'b1;
            S_COMP:  ssfr_d[10]   = 1'b1;
            S_SEL:   ssfr_d[15:13] = selOut_d;
            S_WAITF: ssfr_d[15:13] = selOut_d;
            S_WR: begin
                ssfr_d[15:13] = selOut_d;
                conSig_d[7]   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.IN_READY = inReady_q;
    assign bus.CON_SIG  = conSig_q;
    assign bus.SSFR     = ssfr_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_npu_ctrl_seq.sv
// Directed, cycle-by-cycle bench for npu_ctrl_seq. Each step drives the
// inputs, takes one rising edge, and compares every output against the
// word expected for the phase the sequencer should be in during that cycle.
module tb_npu_ctrl_seq;

    typedef enum int {
        P_IDLE, P_LOAD, P_BUF, P_MAC, P_RELU,
        P_COMP, P_SEL, P_WAITF, P_WR, P_DONE
    } phase_e;

    typedef struct {
        logic   start;
        logic   inValid;
        logic   full;
        logic   abort;
        phase_e expPhase;
    } vec_t;

    logic clk;
    logic rstN;

    int checks;
    int errors;
    int doneCount;
    int doneCycle;
    int bufCount;
    int macCount;
    int cycleNo;

    logic [1:0] curByp;
    logic [2:0] curSel;

    vec_t   tbl[11];
    phase_e expSeq[$];

    npu_ctrl_seq_if #(.CNT_W(8)) bus ();

    npu_ctrl_seq #(
        .CNT_W      (8),
        .RELU_CYCLES(2)
    ) dut (
        .CLKEXT(clk),
        .RST   (rstN),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {IN_READY, BUSY, DONE, CON_SIG, SSFR} for a given phase
    function automatic logic [34:0] expOut(phase_e p, logic [1:0] byp, logic [2:0] sel);
        logic [15:0] con;
        logic [15:0] ssfr;
        con  = 16'h0000;
        ssfr = 16'h0000;
        if (p != P_IDLE) ssfr[12:11] = byp;
        if (p == P_BUF)  con[15] = 1'b1;
        if (p == P_MAC)  con[13] = 1'b1;
        if (p == P_RELU) con[11] = 1'b1;
        if (p == P_WR)   con[7]  = 1'b1;
        if (p == P_COMP) ssfr[10] = 1'b1;
        if (p == P_SEL || p == P_WAITF || p == P_WR) ssfr[15:13] = sel;
        return {(p == P_LOAD), (p != P_IDLE), (p == P_DONE), con, ssfr};
    endfunction

    task automatic setConfig(input logic [7:0] nMac, input logic [7:0] nGroups,
                             input logic [1:0] byp, input logic [2:0] sel);
        bus.N_MAC       = nMac;
        bus.N_GROUPS    = nGroups;
        bus.BYPASS_RELU = byp;
        bus.SEL_OUT_CFG = sel;
    endtask

    task automatic applyStimulus(input logic start, input logic inValid,
                                 input logic full, input logic abort);
        bus.START    = start;
        bus.IN_VALID = inValid;
        bus.FULL     = full;
        bus.ABORT    = abort;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input phase_e p);
        logic [34:0] act;
        logic [34:0] exp;
        act = {bus.IN_READY, bus.BUSY, bus.DONE, bus.CON_SIG, bus.SSFR};
        exp = expOut(p, curByp, curSel);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got rdy/busy/done=%b%b%b con=%h ssfr=%h, expected rdy/busy/done=%b%b%b con=%h ssfr=%h",
                     name, act[34], act[33], act[32], act[31:16], act[15:0],
                     exp[34], exp[33], exp[32], exp[31:16], exp[15:0]);
        end
        if (bus.DONE === 1'b1) begin
            doneCount++;
            doneCycle = cycleNo;
        end
        if (bus.CON_SIG[15] === 1'b1) bufCount++;
        if (bus.CON_SIG[13] === 1'b1) macCount++;
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clearTally();
        doneCount = 0;
        doneCycle = -1;
        bufCount  = 0;
        macCount  = 0;
    endtask

    // Walks expSeq with fixed inputs; cycle numbers continue from cycleNo
    task automatic runSeq(input string tag, input logic start,
                          input logic inValid, input logic full);
        foreach (expSeq[i]) begin
            cycleNo++;
            applyStimulus(start, inValid, full, 1'b0);
            checkOutput($sformatf("%s_c%0d", tag, cycleNo), expSeq[i]);
        end
    endtask

    // Table-driven single-group step: N_MAC=2, N_GROUPS=1
    task automatic runTable(input string tag);
        clearTally();
        setConfig(8'd2, 8'd1, 2'b10, 3'b101);
        curByp  = 2'b10;
        curSel  = 3'b101;
        cycleNo = 0;
        for (int i = 0; i < 11; i++) begin
            cycleNo = i + 1;
            applyStimulus(tbl[i].start, tbl[i].inValid, tbl[i].full, tbl[i].abort);
            checkOutput($sformatf("%s_c%0d", tag, cycleNo), tbl[i].expPhase);
        end
        checkValue({tag, "_doneCycle"}, doneCycle, 10);
        checkValue({tag, "_doneCount"}, doneCount, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clearTally();
        cycleNo = 0;
        curByp  = 2'b00;
        curSel  = 3'b000;

        // Cycle n is the interval after edge n-1; START is sampled at edge 0
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, P_LOAD};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_BUF};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_MAC};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_MAC};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_RELU};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_RELU};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_COMP};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_SEL};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_WR};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_DONE};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, P_IDLE};

        bus.START    = 1'b0;
        bus.ABORT    = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.FULL     = 1'b0;
        setConfig(8'd0, 8'd0, 2'b00, 3'b000);

        // Reset values, both while held and after release
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", P_IDLE);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_released", P_IDLE);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("abort_in_idle", P_IDLE);

        // Basic step
        runTable("s1");

        // Three groups with N_MAC=1
        clearTally();
        setConfig(8'd1, 8'd3, 2'b01, 3'b010);
        curByp  = 2'b01;
        curSel  = 3'b010;
        cycleNo = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("s2_c1", P_LOAD);
        expSeq = '{P_BUF, P_MAC, P_LOAD, P_BUF, P_MAC, P_LOAD, P_BUF, P_MAC,
                   P_RELU, P_RELU, P_COMP, P_SEL, P_WR, P_DONE, P_IDLE};
        runSeq("s2", 1'b0, 1'b1, 1'b0);
        checkValue("s2_bufPulses", bufCount, 3);
        checkValue("s2_macCycles", macCount, 3);
        checkValue("s2_doneCycle", doneCycle, 15);

        // Feeder stalls five cycles in LOAD
        clearTally();
        setConfig(8'd2, 8'd1, 2'b11, 3'b110);
        curByp  = 2'b11;
        curSel  = 3'b110;
        cycleNo = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_c1", P_LOAD);
        expSeq = '{P_LOAD, P_LOAD, P_LOAD, P_LOAD, P_LOAD};
        runSeq("s3", 1'b0, 1'b0, 1'b0);
        expSeq = '{P_BUF, P_MAC, P_MAC, P_RELU, P_RELU, P_COMP, P_SEL,
                   P_WR, P_DONE, P_IDLE};
        runSeq("s3", 1'b0, 1'b1, 1'b0);
        checkValue("s3_doneCycle", doneCycle, 15);
        checkValue("s3_bufPulses", bufCount, 1);

        // FIFO full entering SEL, released after four WAITF cycles
        clearTally();
        setConfig(8'd2, 8'd1, 2'b01, 3'b011);
        curByp  = 2'b01;
        curSel  = 3'b011;
        cycleNo = 1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("s4_c1", P_LOAD);
        expSeq = '{P_BUF, P_MAC, P_MAC, P_RELU, P_RELU, P_COMP, P_SEL,
                   P_WAITF, P_WAITF, P_WAITF, P_WAITF};
        runSeq("s4", 1'b0, 1'b1, 1'b1);
        expSeq = '{P_WR, P_DONE, P_IDLE};
        runSeq("s4", 1'b0, 1'b1, 1'b0);
        checkValue("s4_doneCycle", doneCycle, 14);

        // ABORT during MAC
        clearTally();
        setConfig(8'd2, 8'd1, 2'b10, 3'b111);
        curByp  = 2'b10;
        curSel  = 3'b111;
        cycleNo = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("s5a_c1", P_LOAD);
        expSeq = '{P_BUF, P_MAC};
        runSeq("s5a", 1'b0, 1'b1, 1'b0);
        cycleNo++;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("s5a_abort", P_IDLE);
        expSeq = '{P_IDLE, P_IDLE, P_IDLE};
        runSeq("s5a", 1'b0, 1'b1, 1'b0);
        checkValue("s5a_doneCount", doneCount, 0);

        // Asynchronous reset during RELU
        clearTally();
        cycleNo = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("s5b_c1", P_LOAD);
        expSeq = '{P_BUF, P_MAC, P_MAC, P_RELU};
        runSeq("s5b", 1'b0, 1'b1, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("s5b_rst_immediate", P_IDLE);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s5b_after_rst", P_IDLE);
        checkValue("s5b_doneCount", doneCount, 0);

        // A fresh START after the abort and reset still runs a full step
        runTable("s5c");

        // Zero config clamped to 1/1, START held and config changed while busy
        clearTally();
        setConfig(8'd0, 8'd0, 2'b11, 3'b001);
        curByp  = 2'b11;
        curSel  = 3'b001;
        cycleNo = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("s6_c1", P_LOAD);
        setConfig(8'd5, 8'd4, 2'b00, 3'b110);
        expSeq = '{P_BUF, P_MAC, P_RELU, P_RELU, P_COMP, P_SEL, P_WR, P_DONE, P_IDLE};
        runSeq("s6", 1'b1, 1'b1, 1'b0);
        expSeq = '{P_IDLE, P_IDLE, P_IDLE};
        runSeq("s6", 1'b0, 1'b1, 1'b0);
        checkValue("s6_doneCount", doneCount, 1);
        checkValue("s6_doneCycle", doneCycle, 9);
        checkValue("s6_macCycles", macCount, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
